pcg32_rr_server: RTL and testbench
==================================

// Module: pcg32_rr_server
// PURPOSE
//  Shared PCG32 (XSH-RR, 64-bit LCG state) random-number server for N requesters.
//  Owns the generator state; round-robin arbitration grants one 32-bit word per cycle.
//  Supports runtime reseeding with the standard PCG srandom sequence.
//  Sits between the PCG32 datapath and consumers that need independent draws.
// PARAMETERS
//  N          4                      number of requesters (2..16)
//  INIT_STATE 64'h4d595df4d0f33173   state loaded on reset
//  MULT       64'd6364136223846793005 LCG multiplier
//  INC        64'd1442695040888963407 LCG increment (odd); used when PCG32_SRV_SEQ_EN undefined
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  req        in   N       per-requester draw request, level
//  gnt        out  N       one-hot grant, 1-cycle pulse, registered
//  rand_valid out  1       rand_data/rand_id valid this cycle (== |gnt)
//  rand_data  out  32      permuted output word
//  rand_id    out  clog2N  index of granted requester
//  seed_valid in   1       reseed request
//  seed       in   64      initstate for reseed
//  seed_ready out  1       1 in RUN state; seed accepted when seed_valid&seed_ready
//  busy       out  1       1 in SEED_A/SEED_B
// BEHAVIOUR
//  Reset: state<=INIT_STATE, inc<=INC, FSM<=RUN, rr pointer<=0, gnt=0, rand_valid=0,
//   rand_data=0, rand_id=0, busy=0. Reset mid-seed abandons the seed; no partial state kept.
//  Step: next = state*MULT + inc, mod 2^64 (low 64 bits of product).
//  Permute (on current state): x = ((state>>18)^state)>>27, low 32 bits; r = state[63:59];
//   out = rotate_right32(x, r); r==0 -> out = x (no shift-by-32 hazard).
//  FSM RUN: if seed_valid (priority over req): latch seed, no grant, -> SEED_A.
//   else if |req: pick winner round-robin, next cycle gnt[w]=1, rand_valid=1,
//   rand_data=permute(state), rand_id=w, state<=step(state), ptr<=w+1 (wraps N-1->0).
//   else: outputs gnt/rand_valid 0, state held.
//  SEED_A: state<=inc+seed (== step(0)+seed), seed_ready=0, busy=1 -> SEED_B.
//  SEED_B: state<=step(state), busy=1 -> RUN. No grants in SEED_A/SEED_B; req ignored.
//  Round-robin: search from ptr upward with wrap; lowest index >= ptr wins, else lowest overall.
//   After reset requester 0 has top priority.
//  Latency: req sampled at edge k -> gnt/rand_data valid during cycle k+1. Throughput 1/cycle.
//  Requester holding req after gnt is a new request; each grant consumes exactly one step.
//  rand_data/rand_id hold last value when rand_valid=0.
//  Seed accepted in cycle k: first grant possible at the edge ending SEED_B's cycle,
//   i.e. gnt visible cycle k+3; it returns permute of seeded state.
// CONFIGURATION
//  PCG32_SRV_SEQ_EN defined: extra input seed_seq[62:0]; on seed accept inc<=(seed_seq<<1)|1
//   (PCG stream select), used by SEED_A and all later steps until next reseed or reset.
//  Undefined: no seed_seq port; inc fixed at INC forever.
// TESTING
//  T1 reset, req=4'b0001 held 3 cycles -> 3 gnt[0] pulses; words match C model from INIT_STATE.
//  T2 req=4'b1111 held 8 cycles -> gnt order 0,1,2,3,0,1,2,3; rand_id matches; words sequential.
//  T3 seed_valid with req=4'b0010 same cycle -> no gnt for 2 cycles, busy=1 for 2; then gnt[1].
//  T4 (SEQ_EN) seed=42, seed_seq=54, req[0] held -> rand_data 0xa15c02b7, 0x7b47f409,
//   0xba1d3330, 0x83d2f293, 0xbfa4784b, 0xcbed606e.
//  T5 reset asserted during SEED_A -> next RUN word equals T1 first word; ptr back to 0.
//  T6 req=0 for 10 cycles between grants -> state unchanged; next word = next in C sequence.

Source files
------------

// File: rtl/pcg32_rr_server_if.sv
// pcg32_rr_server_if: request/grant/data/seed bundle between the PCG32 server
// and its consumers. The seed_seq stream selector exists only when
// PCG32_SRV_SEQ_EN is defined.
interface pcg32_rr_server_if #(
  parameter int N = 4
) ();
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           rand_valid;
  logic [31:0]    rand_data;
  logic [IDW-1:0] rand_id;
  logic           seed_valid;
  logic [63:0]    seed;
  logic           seed_ready;
  logic           busy;
`ifdef PCG32_SRV_SEQ_EN
  logic [62:0]    seed_seq;

  modport master (
    output req, seed_valid, seed, seed_seq,
    input  gnt, rand_valid, rand_data, rand_id, seed_ready, busy
  );
  modport slave (
    input  req, seed_valid, seed, seed_seq,
    output gnt, rand_valid, rand_data, rand_id, seed_ready, busy
  );
`else
  modport master (
    output req, seed_valid, seed,
    input  gnt, rand_valid, rand_data, rand_id, seed_ready, busy
  );
  modport slave (
    input  req, seed_valid, seed,
    output gnt, rand_valid, rand_data, rand_id, seed_ready, busy
  );
`endif
endinterface

// File: rtl/pcg32_rr_server.sv
// pcg32_rr_server: one PCG32 (XSH-RR, 64-bit LCG) generator shared by N
// requesters. Round-robin arbitration hands out one 32-bit word per cycle, and
// the generator can be reseeded at runtime with the PCG srandom sequence.
// Build option: define PCG32_SRV_SEQ_EN to add the seed_seq stream selector.
module pcg32_rr_server #(
  parameter int          N          = 4,
  parameter logic [63:0] INIT_STATE = 64'h4d595df4d0f33173,
  parameter logic [63:0] MULT       = 64'd6364136223846793005,
  parameter logic [63:0] INC        = 64'd1442695040888963407
) (
  input logic              clk,
  input logic              reset,
  pcg32_rr_server_if.slave srv
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SEED_A = 2'd1,
    SEED_B = 2'd2
  } fsm_t;

  // Registered state
  fsm_t           fsm_q;
  logic [63:0]    state_q;
  logic [63:0]    inc_q;
  logic [IDW-1:0] ptr_q;
  logic [N-1:0]   gnt_q;
  logic           rand_valid_q;
  logic [31:0]    rand_data_q;
  logic [IDW-1:0] rand_id_q;
  logic           seed_ready_q;
  logic           busy_q;

  // Combinational helpers
  logic [63:0]    state_step_d;
  logic [31:0]    word_d;
  logic [63:0]    inc_seed_d;
  logic [N-1:0]   req_masked;
  logic [N-1:0]   win_onehot;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] ptr_d;
  logic           seed_accept;
  logic           grant_en;

  // XSH-RR output permutation. Rotating a doubled copy of x keeps r==0 safe
  // (no shift by 32).
  function automatic logic [31:0] permute(input logic [63:0] s);
    logic [31:0] x;
    logic [63:0] xx;
    logic [4:0]  r;
    x  = 32'(((s >> 18) ^ s) >> 27);
    r  = s[63:59];
    xx = {x, x} >> r;
    return xx[31:0];
  endfunction

  // LCG step and permuted word of the current state
  always_comb begin
    state_step_d = state_q * MULT + inc_q;
    word_d       = permute(state_q);
  end

  // Increment that takes effect when a seed is accepted
`ifdef PCG32_SRV_SEQ_EN
  assign inc_seed_d = {srv.seed_seq, 1'b1};
`else
  assign inc_seed_d = INC;
`endif

  // Requesters at or above the round-robin pointer get first look
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign req_masked[gi] = srv.req[gi] && (gi >= int'(ptr_q));
  end

  // Winner: lowest masked requester, else lowest requester overall
  always_comb begin
    win_found = |srv.req;
    win_idx   = '0;
    if (|req_masked) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_masked[i]) win_idx = IDW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (srv.req[i]) win_idx = IDW'(i);
      end
    end
    ptr_d = (win_idx == IDW'(N - 1)) ? '0 : win_idx + IDW'(1);
  end

  // One-hot form of the winner for the grant register
  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign win_onehot[gi] = (IDW'(gi) == win_idx);
  end

  // A seed in RUN beats any request. The seeded state is already in state_q
  // while in SEED_B, so the SEED_B->RUN edge can serve the first grant.
  always_comb begin
    seed_accept = (fsm_q == RUN) && srv.seed_valid;
    grant_en    = win_found && (((fsm_q == RUN) && !srv.seed_valid) || (fsm_q == SEED_B));
  end

  // Control FSM, generator state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= RUN;
      state_q      <= INIT_STATE;
      inc_q        <= INC;
      ptr_q        <= '0;
      gnt_q        <= '0;
      rand_valid_q <= 1'b0;
      rand_data_q  <= '0;
      rand_id_q    <= '0;
      seed_ready_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      gnt_q        <= '0;
      rand_valid_q <= 1'b0;
      case (fsm_q)
        RUN: begin
          if (seed_accept) begin
            // Equivalent to step(0)+seed: the srandom first phase folded in
            inc_q        <= inc_seed_d;
            state_q      <= inc_seed_d + srv.seed;
            fsm_q        <= SEED_A;
            seed_ready_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        SEED_A: begin
          // Second srandom phase: this produces the seeded state
          state_q <= state_step_d;
          fsm_q   <= SEED_B;
        end
        SEED_B: begin
          fsm_q        <= RUN;
          seed_ready_q <= 1'b1;
          busy_q       <= 1'b0;
        end
        default: begin
          fsm_q        <= RUN;
          seed_ready_q <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase

      if (grant_en) begin
        gnt_q        <= win_onehot;
        rand_valid_q <= 1'b1;
        rand_data_q  <= word_d;
        rand_id_q    <= win_idx;
        state_q      <= state_step_d;
        ptr_q        <= ptr_d;
      end
    end
  end

  assign srv.gnt        = gnt_q;
  assign srv.rand_valid = rand_valid_q;
  assign srv.rand_data  = rand_data_q;
  assign srv.rand_id    = rand_id_q;
  assign srv.seed_ready = seed_ready_q;
  assign srv.busy       = busy_q;

endmodule

// File: tb/tb_pcg32_rr_server.sv
// tb_pcg32_rr_server: directed checks of grant order, PCG32 words, reseeding
// and reset behaviour of pcg32_rr_server.
module tb_pcg32_rr_server;
  localparam logic [63:0] INIT_STATE = 64'h4d595df4d0f33173;
  localparam logic [63:0] MULT       = 64'd6364136223846793005;
  localparam logic [63:0] INC        = 64'd1442695040888963407;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pcg32_rr_server_if #(.N(4)) bus ();

  pcg32_rr_server #(.N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .srv   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] m_state;
  logic [63:0] m_inc;
  logic [31:0] last_word;
  logic [31:0] exp_word;

  function automatic logic [63:0] m_step(input logic [63:0] s, input logic [63:0] inc);
    return s * MULT + inc;
  endfunction

  function automatic logic [31:0] m_perm(input logic [63:0] s);
    logic [31:0] x;
    int unsigned r;
    x = 32'(((s >> 18) ^ s) >> 27);
    r = s[63:59];
    if (r == 0) return x;
    return (x >> r) | (x << (32 - r));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.seed_valid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_state = INIT_STATE;
    m_inc   = INC;
  endtask

  task automatic test_reset();
    bus.req = '0;
    bus.seed_valid = 1'b0;
    bus.seed = '0;
`ifdef PCG32_SRV_SEQ_EN
    bus.seed_seq = '0;
`endif
    do_reset();
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b expected %b", bus.gnt, 4'b0000); end
    total++; if (bus.rand_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", bus.rand_valid); end
    total++; if (bus.rand_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h expected 00000000", bus.rand_data); end
    total++; if (bus.rand_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d expected 0", bus.rand_id); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    total++; if (bus.seed_ready !== 1'b1) begin bad++; $display("FAIL reset_seed_ready: got %b expected 1", bus.seed_ready); end
    $display("reset: gnt=%b valid=%b data=%h busy=%b", bus.gnt, bus.rand_valid, bus.rand_data, bus.busy);
  endtask

  // req[0] held for 3 cycles -> three gnt[0] pulses with sequential words
  task automatic test_single_requester();
    bus.req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_word = m_perm(m_state);
      m_state  = m_step(m_state, m_inc);
      if (i == 2) bus.req = 4'b0000;
      total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt[%0d]: got %b expected 0001", i, bus.gnt); end
      total++; if (bus.rand_data !== exp_word) begin bad++; $display("FAIL single_data[%0d]: got %h expected %h", i, bus.rand_data, exp_word); end
      $display("single: gnt=%b id=%0d data=%h", bus.gnt, bus.rand_id, bus.rand_data);
    end
    last_word = exp_word;
    tick();
    total++; if (bus.rand_valid !== 1'b0) begin bad++; $display("FAIL single_idle_valid: got %b expected 0", bus.rand_valid); end
    total++; if (bus.rand_data !== last_word) begin bad++; $display("FAIL single_hold_data: got %h expected %h", bus.rand_data, last_word); end
  endtask

  // All requesters held 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3
  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_gnt  = 4'b0001 << (i % 4);
      exp_word = m_perm(m_state);
      m_state  = m_step(m_state, m_inc);
      if (i == 7) bus.req = 4'b0000;
      total++; if (bus.gnt !== exp_gnt) begin bad++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, bus.gnt, exp_gnt); end
      total++; if (bus.rand_id !== 2'(i % 4)) begin bad++; $display("FAIL rr_id[%0d]: got %0d expected %0d", i, bus.rand_id, i % 4); end
      total++; if (bus.rand_data !== exp_word) begin bad++; $display("FAIL rr_data[%0d]: got %h expected %h", i, bus.rand_data, exp_word); end
      $display("rr: gnt=%b id=%0d data=%h", bus.gnt, bus.rand_id, bus.rand_data);
    end
    last_word = exp_word;
  endtask

  // 10 idle cycles must not advance the generator
  task automatic test_idle_hold();
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL idle_gnt[%0d]: got %b expected 0000", i, bus.gnt); end
    end
    total++; if (bus.rand_data !== last_word) begin bad++; $display("FAIL idle_hold_data: got %h expected %h", bus.rand_data, last_word); end
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b0000;
    exp_word = m_perm(m_state);
    m_state  = m_step(m_state, m_inc);
    total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL idle_next_gnt: got %b expected 0100", bus.gnt); end
    total++; if (bus.rand_id !== 2'd2) begin bad++; $display("FAIL idle_next_id: got %0d expected 2", bus.rand_id); end
    total++; if (bus.rand_data !== exp_word) begin bad++; $display("FAIL idle_next_data: got %h expected %h", bus.rand_data, exp_word); end
    $display("idle: gnt=%b id=%0d data=%h", bus.gnt, bus.rand_id, bus.rand_data);
  endtask

  // Seed and req[1] in the same cycle: two busy cycles, then gnt[1] with the
  // first word of the seeded stream
  task automatic test_reseed();
    bus.seed = 64'h0123456789abcdef;
`ifdef PCG32_SRV_SEQ_EN
    bus.seed_seq = 63'd7;
    m_inc = {63'd7, 1'b1};
`endif
    m_state = m_step(64'd0, m_inc) + bus.seed;
    m_state = m_step(m_state, m_inc);
    bus.req = 4'b0010;
    bus.seed_valid = 1'b1;
    tick();
    bus.seed_valid = 1'b0;
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL seed_gnt_a: got %b expected 0000", bus.gnt); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL seed_busy_a: got %b expected 1", bus.busy); end
    total++; if (bus.seed_ready !== 1'b0) begin bad++; $display("FAIL seed_ready_a: got %b expected 0", bus.seed_ready); end
    tick();
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL seed_gnt_b: got %b expected 0000", bus.gnt); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL seed_busy_b: got %b expected 1", bus.busy); end
    tick();
    bus.req = 4'b0000;
    exp_word = m_perm(m_state);
    m_state  = m_step(m_state, m_inc);
    total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL seed_first_gnt: got %b expected 0010", bus.gnt); end
    total++; if (bus.rand_data !== exp_word) begin bad++; $display("FAIL seed_first_data: got %h expected %h", bus.rand_data, exp_word); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL seed_busy_end: got %b expected 0", bus.busy); end
    total++; if (bus.seed_ready !== 1'b1) begin bad++; $display("FAIL seed_ready_end: got %b expected 1", bus.seed_ready); end
    $display("reseed: gnt=%b id=%0d data=%h", bus.gnt, bus.rand_id, bus.rand_data);
  endtask

`ifdef PCG32_SRV_SEQ_EN
  // Reference PCG32 stream: initstate 42, initseq 54
  task automatic test_seq_stream();
    logic [31:0] ref_words [6];
    ref_words = '{32'ha15c02b7, 32'h7b47f409, 32'hba1d3330,
                  32'h83d2f293, 32'hbfa4784b, 32'hcbed606e};
    do_reset();
    bus.seed = 64'd42;
    bus.seed_seq = 63'd54;
    bus.seed_valid = 1'b1;
    bus.req = 4'b0001;
    tick();
    bus.seed_valid = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) bus.req = 4'b0000;
      total++; if (bus.rand_data !== ref_words[i]) begin bad++; $display("FAIL seq_data[%0d]: got %h expected %h", i, bus.rand_data, ref_words[i]); end
      $display("seq: gnt=%b data=%h", bus.gnt, bus.rand_data);
    end
  endtask
`endif

  // Reset during SEED_A: seed discarded, pointer and state back to reset values
  task automatic test_reset_mid_seed();
    do_reset();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL midseed_pre_gnt: got %b expected 0001", bus.gnt); end
    bus.seed = 64'hdeadbeefcafef00d;
    bus.seed_valid = 1'b1;
    tick();
    bus.seed_valid = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midseed_busy: got %b expected 1", bus.busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midseed_busy_rst: got %b expected 0", bus.busy); end
    total++; if (bus.seed_ready !== 1'b1) begin bad++; $display("FAIL midseed_ready_rst: got %b expected 1", bus.seed_ready); end
    bus.req = 4'b1111;
    tick();
    bus.req = 4'b0000;
    exp_word = m_perm(INIT_STATE);
    total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL midseed_gnt: got %b expected 0001", bus.gnt); end
    total++; if (bus.rand_id !== 2'd0) begin bad++; $display("FAIL midseed_id: got %0d expected 0", bus.rand_id); end
    total++; if (bus.rand_data !== exp_word) begin bad++; $display("FAIL midseed_data: got %h expected %h", bus.rand_data, exp_word); end
    $display("midseed: gnt=%b id=%0d data=%h", bus.gnt, bus.rand_id, bus.rand_data);
  endtask

  initial begin
    test_reset();
    test_single_requester();
    test_round_robin();
    test_idle_hold();
    test_reseed();
`ifdef PCG32_SRV_SEQ_EN
    test_seq_stream();
`endif
    test_reset_mid_seed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
